instr_mem_pipe: RTL and testbench
=================================

Name: instr_mem_pipe

Overview:
- Parametrised, pipelined instruction memory for the RISC-V core's fetch stage.
- Fetch side: byte-addressed, registered-read fetch port with valid/ready handshake on request and response.
- Programming side: word-write load port, so programs are loaded at run time rather than hard-coded.
- Flags misaligned and out-of-range fetches, and supports a fetch flush on a taken branch.

Parameters:
- XLEN, 32, instruction width in bits.
- DEPTH, 64, number of instruction words; power of two, minimum 4.
- ADDR_W, 32, fetch byte-address width.
- NOP_INSTR, 32'h00000013, word returned on a faulted fetch and after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a clk edge.
- req_addr  in  ADDR_W  byte address of the fetch.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  XLEN  fetched instruction.
- rsp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out of range.
- rsp_addr  out  ADDR_W  echo of the request address.
- flush  in  1  discard the pending response; block acceptance this cycle.
- load_en  in  1  write load_data into the array.
- load_idx  in  $clog2(DEPTH)  word index to write.
- load_data  in  XLEN  word to write.
- busy  out  1  high while in LOAD or TURN.

Behaviour:
- Reset values (synchronous, rst high at an edge): state=RUN, rsp_valid=0, rsp_instr=NOP_INSTR, rsp_fault=00, rsp_addr=0, busy=0. Array contents are not cleared by reset.
- Address decode:
  - idx = req_addr[$clog2(DEPTH)+1:2].
  - Misaligned if req_addr[1:0] != 0.
  - Out of range if req_addr >= DEPTH*4.
  - Misaligned takes precedence when both apply.
- Faulted fetch returns rsp_instr=NOP_INSTR and never reads the array.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N; the response is visible in cycle N+1.
- Throughput: 1 fetch per cycle while rsp_ready stays high.
- req_ready = (state==RUN) && !flush && !load_en && (!rsp_valid || rsp_ready).
- Stall: while rsp_valid=1 and rsp_ready=0, rsp_instr, rsp_fault and rsp_addr hold stable and no request is accepted.
- Response retire: rsp_valid falls after an edge with rsp_ready=1, unless a new request is accepted on that same edge.
- flush: rsp_valid=0 after the edge, regardless of rsp_ready. No acceptance that cycle.
- flush + rst together: rst wins; the outcome is identical anyway.
- State machine:
  - RUN --load_en--> LOAD.
  - LOAD: each cycle with load_en=1 writes mem[load_idx] <= load_data.
  - LOAD --load_en=0--> TURN.
  - TURN --1 cycle--> RUN.
  - TURN guarantees a fetch never reads a word written in the same or the previous cycle.
- Entering LOAD while rsp_valid=1: the pending response is held, still drains via rsp_ready, and is not corrupted.
- Load in RUN: a write in the same cycle as load_en's first assertion is performed. Writes are taken only while load_en=1.
- Reset mid-LOAD: state returns to RUN. Writes already performed persist; no write happens on the reset edge.
- load_idx is always in range by construction; no wrap checks are needed.
- Fetch address wrap: addresses at or above DEPTH*4 fault and do not alias to low words.

Decomposition:
- Package instr_mem_pkg:
  - fault encodings FAULT_OK, FAULT_MISALIGN, FAULT_RANGE.
  - state encodings RUN, LOAD, TURN.
  - default NOP_INSTR.
- Sub-module instr_mem_array: DEPTH x XLEN RAM with synchronous write port and synchronous read port (read enable, registered output); FPGA-BRAM inferable.
- Handshake, fault decode and FSM live in instr_mem_pipe.

Test Plan:
- Load: load_en 3 cycles writing idx 0,1,2 = 32'h00100093, 32'h00008133, 32'h0020A023. Then fetch 0x0, 0x4, 0x8 back-to-back with rsp_ready=1 -> the three words on consecutive cycles, each fault=00, first response 1 cycle after accept; busy high 4 cycles.
- Stall: fetch 0x4 with rsp_ready=0 for 3 cycles -> rsp_instr=32'h00008133 held, req_ready=0. rsp_ready=1 -> retires, next request accepted the same edge.
- Faults (DEPTH=64): fetch 0x6 -> fault=01, instr=32'h00000013. Fetch 0x100 -> fault=10. Fetch 0x102 -> fault=01.
- Flush: accept fetch 0x8; flush in the next cycle with rsp_ready=0 -> rsp_valid=0 afterwards, req_ready=0 during the flush cycle.
- Load during a pending response: rsp_valid=1, rsp_ready=0, then load_en=1 writing idx 2 = 32'hDEADBEEF -> old response unchanged until drained. After TURN, fetch 0x8 returns 32'hDEADBEEF.
- Reset mid-LOAD: rst during the second load cycle -> state RUN, rsp_valid=0, rsp_instr=NOP_INSTR. The first written word is still readable afterwards.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared encodings and defaults for the fetch-stage instruction memory.
package instr_mem_pkg;

    localparam int unsigned FAULT_W = 2;

    typedef enum logic [FAULT_W-1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        LOAD = 2'b01,
        TURN = 2'b10
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    // Misalignment wins over range when both apply.
    function automatic fault_e decode_fault(input logic [1:0] byte_off, input logic over_range);
        fault_e f;
        f = FAULT_OK;
        if (byte_off != 2'b00) begin
            f = FAULT_MISALIGN;
        end else if (over_range) begin
            f = FAULT_RANGE;
        end
        return f;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x XLEN RAM: synchronous write, synchronous read with enable and registered output.
module instr_mem_array #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port; output register holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: fetch handshake, fault decode and run-time load FSM.
module instr_mem_pipe
    import instr_mem_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 64,
    parameter int unsigned     ADDR_W    = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEFAULT_NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_instr,
    output logic [1:0]               rsp_fault,
    output logic [ADDR_W-1:0]        rsp_addr,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [XLEN-1:0]          load_data,
    output logic                     busy
);

    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] RANGE_LIM = (ADDR_W + 1)'(DEPTH * 4);

    state_e           state_q;
    state_e           state_d;
    fault_e           req_fault;
    logic             accept;
    logic             over_range;
    logic             rd_en;
    logic             wr_en;
    logic             rsp_nop;
    logic [IDX_W-1:0] req_idx;
    logic [XLEN-1:0]  rd_data;

    // Address decode; the compare is one bit wider so no address aliases low words.
    always_comb begin
        over_range = ({1'b0, req_addr} >= RANGE_LIM);
        req_idx    = req_addr[IDX_W+1:2];
        req_fault  = decode_fault(req_addr[1:0], over_range);
    end

    assign req_ready = (state_q == RUN) && !flush && !load_en && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_en     = accept && (req_fault == FAULT_OK);
    assign wr_en     = load_en && !rst;

    instr_mem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_idx  (req_idx),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load burst always passes through one TURN cycle before fetching resumes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (load_en)  state_d = LOAD;
            LOAD:    if (!load_en) state_d = TURN;
            TURN:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Busy flag tracks the non-RUN states.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_d != RUN);
        end
    end

    // Response registers: flush beats retire; accept replaces the held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_nop   <= 1'b1;
            rsp_fault <= FAULT_OK;
            rsp_addr  <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_nop   <= (req_fault != FAULT_OK);
            rsp_fault <= req_fault;
            rsp_addr  <= req_addr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Faulted fetches never touch the array; they present the NOP word instead.
    assign rsp_instr = rsp_nop ? NOP_INSTR : rd_data;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: directed scenarios plus random traffic against a reference model.
module tb_instr_mem_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [1:0]    rsp_fault;
    logic [AW-1:0] rsp_addr;
    logic          flush;
    logic          load_en;
    logic [5:0]    load_idx;
    logic [31:0]   load_data;
    logic          busy;

    instr_mem_pipe #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault),
        .rsp_addr (rsp_addr),
        .flush    (flush),
        .load_en  (load_en),
        .load_idx (load_idx),
        .load_data(load_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 fetching, 1 loading, 2 one-cycle turnaround.
    bit          m_known = 0;
    int          m_mode;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [1:0]  m_fault;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_instr_known;
    logic [31:0] mem [DEPTH];
    bit          mem_known [DEPTH];
    bit          m_accept;

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit exp_ready;
        @(negedge clk);
        exp_ready = m_known && (m_mode == 0) && !flush && !load_en && (!m_valid || rsp_ready);
        if (m_known) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            check("rsp_fault", 32'(rsp_fault), 32'(m_fault));
            check("rsp_addr", rsp_addr, m_addr);
            if (m_instr_known) check("rsp_instr", rsp_instr, m_instr);
        end
        m_accept = exp_ready && req_valid;
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_mode = 0; m_valid = 0; m_instr = NOP; m_fault = 0;
            m_addr = 0; m_busy = 0; m_instr_known = 1;
        end else if (m_known) begin
            if (load_en) begin
                mem[load_idx] = load_data;
                mem_known[load_idx] = 1;
            end
            if (flush) begin
                m_valid = 0;
            end else if (m_accept) begin
                m_valid = 1;
                m_addr  = req_addr;
                if (req_addr % 4 != 0)          m_fault = 2'b01;
                else if (req_addr >= DEPTH * 4) m_fault = 2'b10;
                else                            m_fault = 2'b00;
                if (m_fault != 0) begin
                    m_instr = NOP; m_instr_known = 1;
                end else begin
                    m_instr = mem[req_addr / 4]; m_instr_known = mem_known[req_addr / 4];
                end
            end else if (rsp_ready) begin
                m_valid = 0;
            end
            case (m_mode)
                0: if (load_en) m_mode = 1;
                1: if (!load_en) m_mode = 2;
                default: m_mode = 0;
            endcase
            m_busy = (m_mode != 0);
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input bit rdy);
        req_valid = 1; req_addr = a; rsp_ready = rdy;
        step();
        req_valid = 0;
    endtask

    initial begin
        int busy_cnt;
        int r;
        int lb;
        for (int i = 0; i < DEPTH; i++) mem_known[i] = 0;
        rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
        load_en = 0; load_idx = 0; load_data = 0;
        step(); step();
        rst = 0;
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_instr", rsp_instr, NOP);
        check("reset_busy", 32'(busy), 32'd0);

        // Program load then back-to-back fetch.
        busy_cnt = 0;
        load_en = 1;
        for (int i = 0; i < 3; i++) begin
            load_idx = 6'(i);
            load_data = (i == 0) ? 32'h0010_0093 : (i == 1) ? 32'h0000_8133 : 32'h0020_A023;
            step();
            if (busy) busy_cnt++;
        end
        load_en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd4);
        fetch(32'h0, 1);
        check("f0_valid", 32'(rsp_valid), 32'd1);
        check("f0_instr", rsp_instr, 32'h0010_0093);
        fetch(32'h4, 1);
        check("f4_instr", rsp_instr, 32'h0000_8133);
        fetch(32'h8, 1);
        check("f8_instr", rsp_instr, 32'h0020_A023);
        check("f8_fault", 32'(rsp_fault), 32'd0);
        step();

        // Stall then retire with same-edge acceptance.
        fetch(32'h4, 0);
        req_valid = 1; req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", rsp_instr, 32'h0000_8133);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        #1 check("retire_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 0;
        check("after_stall", rsp_instr, 32'h0010_0093);

        // Fault decode.
        fetch(32'h6, 1);
        check("mis_fault", 32'(rsp_fault), 32'd1);
        check("mis_instr", rsp_instr, NOP);
        fetch(32'h100, 1);
        check("range_fault", 32'(rsp_fault), 32'd2);
        fetch(32'h102, 1);
        check("both_fault", 32'(rsp_fault), 32'd1);

        // Flush with the consumer stalled.
        fetch(32'h8, 1);
        rsp_ready = 0; flush = 1;
        #1 check("flush_ready", 32'(req_ready), 32'd0);
        step();
        flush = 0;
        check("flush_valid", 32'(rsp_valid), 32'd0);

        // Load while a response is pending.
        fetch(32'h4, 0);
        load_en = 1; load_idx = 6'd2; load_data = 32'hDEAD_BEEF;
        step();
        load_en = 0;
        check("pend_instr", rsp_instr, 32'h0000_8133);
        check("pend_valid", 32'(rsp_valid), 32'd1);
        step();
        check("pend_turn", rsp_instr, 32'h0000_8133);
        rsp_ready = 1;
        step();
        check("pend_drain", 32'(rsp_valid), 32'd0);
        fetch(32'h8, 1);
        check("new_word", rsp_instr, 32'hDEAD_BEEF);
        step();

        // Reset during a load burst.
        load_en = 1; load_idx = 6'd5; load_data = 32'h1111_1111;
        step();
        load_idx = 6'd6; load_data = 32'h2222_2222; rst = 1;
        step();
        rst = 0; load_en = 0;
        check("rl_valid", 32'(rsp_valid), 32'd0);
        check("rl_instr", rsp_instr, NOP);
        check("rl_busy", 32'(busy), 32'd0);
        fetch(32'h14, 1);
        check("rl_word", rsp_instr, 32'h1111_1111);
        step();

        // Random traffic: fill the array, then mix everything.
        load_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            load_idx = 6'(i); load_data = $urandom;
            step();
        end
        load_en = 0;
        lb = 0;
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            if (lb > 0) begin
                load_en = 1; lb--;
            end else begin
                load_en = 0;
                if ($urandom_range(0, 29) == 0) lb = $urandom_range(1, 4);
            end
            load_idx  = 6'($urandom_range(0, DEPTH - 1));
            load_data = $urandom;
            req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7)       req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) req_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) req_addr = 32'($urandom_range(DEPTH * 4, DEPTH * 8 - 1));
            else             req_addr = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 0; flush = 0; load_en = 0; req_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
